// File: rtl/xbar_master_queue.sv
// Master-side request queue for one crossbar master port.
// Buffers DEPTH transactions and issues them one at a time until acked.
module xbar_master_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         t_req,
  input  logic                         t_cmd,
  input  logic [31:0]                  t_addr,
  input  logic [31:0]                  t_wdata,
  output logic                         t_full,
  output logic                         t_drop,
  output logic                         o_req,
  output logic                         o_cmd,
  output logic [31:0]                  o_addr,
  output logic [31:0]                  o_wdata,
  input  logic                         i_ack,
  input  logic [31:0]                  i_rdata,
  output logic                         r_valid,
  output logic [31:0]                  r_addr,
  output logic [31:0]                  r_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            t_full_q, t_full_d;
  logic            t_drop_q, t_drop_d;
  logic            o_req_q, o_req_d;
  logic            o_cmd_q, o_cmd_d;
  logic [31:0]     o_addr_q, o_addr_d;
  logic [31:0]     o_wdata_q, o_wdata_d;
  logic            r_valid_q, r_valid_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [31:0]     r_rdata_q, r_rdata_d;

  logic            cmd_mem   [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];
  logic [31:0]     wdata_mem [DEPTH];

  logic            accept;
  logic            pop;
  logic            go_busy;

  always_comb begin
    state_d   = state_q;
    o_req_d   = o_req_q;
    o_cmd_d   = o_cmd_q;
    o_addr_d  = o_addr_q;
    o_wdata_d = o_wdata_q;
    r_valid_d = 1'b0;
    r_addr_d  = r_addr_q;
    r_rdata_d = r_rdata_q;
    go_busy   = 1'b0;

    // a full queue drops the push even if this cycle also pops
    accept   = t_req && !t_full_q;
    t_drop_d = t_req && t_full_q;
    pop      = (state_q == BUSY) && i_ack;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) go_busy = 1'b1;
      end
      BUSY: begin
        if (i_ack) begin
          state_d   = DONE;
          o_req_d   = 1'b0;
          o_cmd_d   = 1'b0;
          o_addr_d  = '0;
          o_wdata_d = '0;
          if (!cmd_mem[rptr_q]) begin
            r_valid_d = 1'b1;
            r_addr_d  = addr_mem[rptr_q];
            r_rdata_d = i_rdata;
          end
        end
      end
      DONE: begin
        if (count_q != '0) go_busy = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_busy) begin
      state_d   = BUSY;
      o_req_d   = 1'b1;
      o_cmd_d   = cmd_mem[rptr_q];
      o_addr_d  = addr_mem[rptr_q];
      o_wdata_d = wdata_mem[rptr_q];
    end

    wptr_d   = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    count_d  = count_q + CW'(accept) - CW'(pop);
    t_full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      t_full_q  <= 1'b0;
      t_drop_q  <= 1'b0;
      o_req_q   <= 1'b0;
      o_cmd_q   <= 1'b0;
      o_addr_q  <= '0;
      o_wdata_q <= '0;
      r_valid_q <= 1'b0;
      r_addr_q  <= '0;
      r_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      t_full_q  <= t_full_d;
      t_drop_q  <= t_drop_d;
      o_req_q   <= o_req_d;
      o_cmd_q   <= o_cmd_d;
      o_addr_q  <= o_addr_d;
      o_wdata_q <= o_wdata_d;
      r_valid_q <= r_valid_d;
      r_addr_q  <= r_addr_d;
      r_rdata_q <= r_rdata_d;
    end
  end

  // storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      cmd_mem[wptr_q]   <= t_cmd;
      addr_mem[wptr_q]  <= t_addr;
      wdata_mem[wptr_q] <= t_wdata;
    end
  end

  assign t_full  = t_full_q;
  assign t_drop  = t_drop_q;
  assign o_req   = o_req_q;
  assign o_cmd   = o_cmd_q;
  assign o_addr  = o_addr_q;
  assign o_wdata = o_wdata_q;
  assign r_valid = r_valid_q;
  assign r_addr  = r_addr_q;
  assign r_rdata = r_rdata_q;
  assign count   = count_q;

endmodule

// File: tb/tb_xbar_master_queue.sv
// Bench for xbar_master_queue: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_xbar_master_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          t_req = 1'b0;
  logic          t_cmd = 1'b0;
  logic [31:0]   t_addr = '0;
  logic [31:0]   t_wdata = '0;
  logic          t_full, t_drop;
  logic          o_req, o_cmd;
  logic [31:0]   o_addr, o_wdata;
  logic          i_ack = 1'b0;
  logic [31:0]   i_rdata = '0;
  logic          r_valid;
  logic [31:0]   r_addr, r_rdata;
  logic [CW-1:0] count;

  xbar_master_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .t_req(t_req), .t_cmd(t_cmd),
    .t_addr(t_addr), .t_wdata(t_wdata),
    .t_full(t_full), .t_drop(t_drop),
    .o_req(o_req), .o_cmd(o_cmd),
    .o_addr(o_addr), .o_wdata(o_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .r_valid(r_valid), .r_addr(r_addr),
    .r_rdata(r_rdata), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  ent_t        mq[$];
  bit          m_issue = 0;
  bit          m_tdrop = 0;
  bit          m_rvalid = 0;
  logic [31:0] m_raddr = '0;
  logic [31:0] m_rdata = '0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: the head stays queued while issued; an issue starts on any
  // edge where nothing is in flight and the queue was non-empty.
  always @(posedge clk) begin
    int   old_n;
    bit   pop;
    ent_t h;
    if (reset) begin
      mq.delete();
      m_issue  = 0;
      m_tdrop  = 0;
      m_rvalid = 0;
      m_raddr  = '0;
      m_rdata  = '0;
    end else begin
      old_n    = mq.size();
      pop      = m_issue && i_ack;
      m_tdrop  = t_req && (old_n == DEPTH);
      m_rvalid = 0;
      if (pop) begin
        h = mq.pop_front();
        if (!h.cmd) begin
          m_rvalid = 1;
          m_raddr  = h.addr;
          m_rdata  = i_rdata;
        end
      end
      if (t_req && old_n < DEPTH)
        mq.push_back('{t_cmd, t_addr, t_wdata});
      if (m_issue) m_issue = !i_ack;
      else m_issue = (old_n > 0);
    end
  end

  always @(negedge clk) begin
    ent_t hd;
    if (chk_en) begin
      hd = m_issue ? mq[0] : '0;
      check("count", 64'(count), 64'(mq.size()));
      check("t_full", 64'(t_full), 64'(mq.size() == DEPTH));
      check("t_drop", 64'(t_drop), 64'(m_tdrop));
      check("o_req", 64'(o_req), 64'(m_issue));
      check("o_cmd", 64'(o_cmd), 64'(hd.cmd));
      check("o_addr", 64'(o_addr), 64'(hd.addr));
      check("o_wdata", 64'(o_wdata), 64'(hd.wdata));
      check("r_valid", 64'(r_valid), 64'(m_rvalid));
      check("r_addr", 64'(r_addr), 64'(m_raddr));
      check("r_rdata", 64'(r_rdata), 64'(m_rdata));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(logic c, logic [31:0] a, logic [31:0] w);
    t_req = 1'b1;
    t_cmd = c;
    t_addr = a;
    t_wdata = w;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_o_req", 64'(o_req), 64'd0);

    // single write
    push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    t_req = 1'b0;
    check("wr_count1", 64'(count), 64'd1);
    check("wr_req_early", 64'(o_req), 64'd0);
    tick();
    check("wr_o_req", 64'(o_req), 64'd1);
    check("wr_o_addr", 64'(o_addr), 64'h10);
    check("wr_o_wdata", 64'(o_wdata), 64'hDEAD_BEEF);
    check("wr_o_cmd", 64'(o_cmd), 64'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("wr_done_req", 64'(o_req), 64'd0);
    check("wr_r_valid", 64'(r_valid), 64'd0);
    check("wr_count0", 64'(count), 64'd0);
    repeat (2) tick();

    // single read with a 3-cycle wait
    push(1'b0, 32'h8000_0004, 32'h5555_AAAA);
    tick();
    t_req = 1'b0;
    tick();
    check("rd_busy0", 64'(o_addr), 64'h8000_0004);
    repeat (3) begin
      tick();
      check("rd_hold_req", 64'(o_req), 64'd1);
      check("rd_hold_addr", 64'(o_addr), 64'h8000_0004);
    end
    i_ack = 1'b1;
    i_rdata = 32'h1234_5678;
    tick();
    i_ack = 1'b0;
    i_rdata = '0;
    check("rd_r_valid", 64'(r_valid), 64'd1);
    check("rd_r_rdata", 64'(r_rdata), 64'h1234_5678);
    check("rd_r_addr", 64'(r_addr), 64'h8000_0004);
    tick();
    check("rd_pulse_end", 64'(r_valid), 64'd0);
    check("rd_hold_data", 64'(r_rdata), 64'h1234_5678);

    // fill and drain
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 32'h100 + 32'(i) * 4, 32'(i));
      tick();
      if (i == 3) check("fill_full", 64'(t_full), 64'd1);
      if (i == 4) check("fill_drop", 64'(t_drop), 64'd1);
    end
    t_req = 1'b0;
    tick();
    check("fill_drop_end", 64'(t_drop), 64'd0);
    i_ack = 1'b1;
    repeat (14) tick();
    i_ack = 1'b0;
    check("drain_count", 64'(count), 64'd0);

    // simultaneous push and pop at count 2
    push(1'b0, 32'hA0, 32'h0);
    tick();
    push(1'b1, 32'hB0, 32'h1);
    tick();
    check("sim_req", 64'(o_req), 64'd1);
    check("sim_cnt_pre", 64'(count), 64'd2);
    push(1'b0, 32'hC0, 32'h2);
    i_ack = 1'b1;
    i_rdata = 32'hCAFE_0001;
    tick();
    t_req = 1'b0;
    i_ack = 1'b0;
    check("sim_cnt", 64'(count), 64'd2);
    i_ack = 1'b1;
    repeat (10) tick();
    i_ack = 1'b0;

    // wrap-around: ten push/complete pairs
    for (int k = 0; k < 10; k++) begin
      push(k[0], 32'h200 + 32'(k), 32'(k) * 3);
      tick();
      t_req = 1'b0;
      i_ack = 1'b1;
      i_rdata = $urandom;
      repeat (3) tick();
      i_ack = 1'b0;
    end

    // reset while busy with 3 entries queued
    push(1'b0, 32'h300, 32'h0);
    tick();
    push(1'b0, 32'h304, 32'h0);
    tick();
    push(1'b1, 32'h308, 32'h0);
    tick();
    t_req = 1'b0;
    check("rb_req", 64'(o_req), 64'd1);
    check("rb_count", 64'(count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_o_req", 64'(o_req), 64'd0);
    check("rb_count0", 64'(count), 64'd0);
    check("rb_o_addr", 64'(o_addr), 64'd0);
    check("rb_r_rdata", 64'(r_rdata), 64'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("rb_late_ack", 64'(r_valid), 64'd0);
    push(1'b0, 32'h400, 32'h0);
    tick();
    t_req = 1'b0;
    tick();
    check("rb_reissue", 64'(o_addr), 64'h400);
    i_ack = 1'b1;
    repeat (3) tick();
    i_ack = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      t_req   = ($urandom_range(99) < 50);
      t_cmd   = $urandom;
      t_addr  = $urandom;
      t_wdata = $urandom;
      i_ack   = ($urandom_range(99) < 40);
      i_rdata = $urandom;
      reset   = ($urandom_range(999) < 8);
      tick();
    end
    reset = 1'b0;
    t_req = 1'b0;
    i_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
